// File: rtl/wide_sub_sequencer.sv
// Byte-serial wide subtractor: one 8-bit ripple slice, LSB first.
// Optional zero flag output when SUB_SEQ_ZERO_FLAG_EN is defined.

module sub8_ripple (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Bin,
  output logic [7:0] Diff,
  output logic       Bout
);

  logic [8:0] br;

  // borrow ripples from bit 0 up through bit 7
  always_comb begin
    br    = '0;
    Diff  = '0;
    br[0] = Bin;
    for (int i = 0; i < 8; i++) begin
      Diff[i]  = A[i] ^ B[i] ^ br[i];
      br[i+1]  = (~A[i] & B[i])
               | (~(A[i] ^ B[i]) & br[i]);
    end
    Bout = br[8];
  end

endmodule

module wide_sub_sequencer #(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout,
`ifdef SUB_SEQ_ZERO_FLAG_EN
  output logic         zero,
`endif
  output logic         busy
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  diff_q;
  logic          brw_q;
  logic          bout_q;
  logic          ovalid_q;
  logic [IW-1:0] idx_q;
  logic [7:0]    sa;
  logic [7:0]    sb;
  logic [7:0]    sd;
  logic          so;
  logic          last;

  assign last = (idx_q == LAST);
  assign sa   = a_q[{idx_q, 3'b000} +: 8];
  assign sb   = b_q[{idx_q, 3'b000} +: 8];

  sub8_ripple u_sub (
    .A    (sa),
    .B    (sb),
    .Bin  (brw_q),
    .Diff (sd),
    .Bout (so)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state: accept, walk slices, wait for consumer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last)     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // operand latch, per-slice result write and borrow chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      brw_q    <= 1'b0;
      bout_q   <= 1'b0;
      ovalid_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            brw_q  <= bin;
            idx_q  <= '0;
            diff_q <= '0;
          end
        end
        RUN: begin
          diff_q[{idx_q, 3'b000} +: 8] <= sd;
          brw_q <= so;
          if (last) begin
            idx_q    <= '0;
            bout_q   <= so;
            ovalid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) ovalid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SUB_SEQ_ZERO_FLAG_EN
  logic zero_q;

  // sticky AND of per-slice zero results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE:    if (in_valid) zero_q <= 1'b1;
        RUN:     zero_q <= zero_q & (sd == 8'h00);
        DONE:    if (out_ready) zero_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign zero = zero_q;
`endif

  assign in_ready  = rst_n & (state_q == IDLE);
  assign out_valid = ovalid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_wide_sub_sequencer.sv
// Scoreboard bench for wide_sub_sequencer at NBYTES=4.
// Zero flag checks are active when SUB_SEQ_ZERO_FLAG_EN is defined.

module tb_wide_sub_sequencer;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
`ifdef SUB_SEQ_ZERO_FLAG_EN
  logic         zero;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    logic         z;
  } exp_t;

  exp_t sbq[$];

  wide_sub_sequencer #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
`ifdef SUB_SEQ_ZERO_FLAG_EN
    .zero      (zero),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_op(input logic [W-1:0] aa,
                         input logic [W-1:0] bb,
                         input logic bi);
    exp_t e;
    logic [W:0] r;
    r   = {1'b0, aa} - {1'b0, bb} - (W+1)'(bi);
    e.d = r[W-1:0];
    e.b = r[W];
    e.z = (r[W-1:0] == '0);
    sbq.push_back(e);
  endtask

  task automatic send(input logic [W-1:0] aa,
                      input logic [W-1:0] bb,
                      input logic bi);
    int lat;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready got %b want 1", in_ready);
    end
    a = aa; b = bb; bin = bi; in_valid = 1'b1;
    push_op(aa, bb, bi);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; bin = ~bi;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != NB) begin
      errors++;
      $display("FAIL latency got %0d want %0d", lat, NB);
    end
  endtask

  task automatic collect();
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got 0 want >0");
      return;
    end
    e = sbq.pop_front();
    if (diff !== e.d || bout !== e.b || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL result got v=%b d=%h b=%b want v=1 d=%h b=%b",
               out_valid, diff, bout, e.d, e.b);
    end
`ifdef SUB_SEQ_ZERO_FLAG_EN
    checks++;
    if (zero !== e.z) begin
      errors++;
      $display("FAIL zero got %b want %b", zero, e.z);
    end
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL handoff got v=%b r=%b busy=%b want 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || diff !== '0 ||
        bout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset got r=%b v=%b d=%h b=%b busy=%b want 0 0 0 0 0",
               in_ready, out_valid, diff, bout, busy);
    end
`ifdef SUB_SEQ_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_zero got %b want 0", zero);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    send(32'h0000_0005, 32'h0000_0003, 1'b0); collect();
    send(32'h0000_0100, 32'h0000_0001, 1'b0); collect();
    send(32'h0000_0000, 32'h0000_0001, 1'b0); collect();
    send(32'h1234_5678, 32'h1234_5677, 1'b1); collect();
  endtask

  task automatic test_hold();
    exp_t e;
    send(32'hA5A5_0001, 32'h0000_0002, 1'b0);
    e = sbq[0];
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        a = 32'h1; b = 32'h1; bin = 1'b0; in_valid = 1'b1;
      end
      if (i == 5) in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || diff !== e.d || bout !== e.b ||
          in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold got v=%b d=%h b=%b r=%b want 1 %h %b 0",
                 out_valid, diff, bout, in_ready, e.d, e.b);
      end
    end
    in_valid = 1'b0;
    collect();
    for (int i = 0; i < NB + 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dropped_pulse got busy=%b v=%b want 0 0",
                 busy, out_valid);
      end
    end
  endtask

  task automatic test_abort();
    a = 32'hFFFF_0000; b = 32'h0000_1111; bin = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || diff !== '0 || bout !== 1'b0 ||
        busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort got v=%b d=%h b=%b busy=%b r=%b want 0",
               out_valid, diff, bout, busy, in_ready);
    end
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_release got r=%b v=%b want 1 0",
               in_ready, out_valid);
    end
    @(posedge clk); #1;
    send(32'h0000_0005, 32'h0000_0003, 1'b0);
    collect();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i == 2) ? ra : W'($urandom);
      rc = 1'($urandom);
      out_ready = (i % 2 == 1);
      send(ra, rb, rc);
      collect();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_abort();
    test_back_to_back();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
